hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard controller beside the ID stage. It detects load-use hazards and
//   hazards on operands of branches resolved in ID, checking against EX and
//   MEM. It stalls PC and IF/ID, injects ID/EX bubbles, flushes IF/ID on
//   taken branches and counts stall and flush events.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   id_rs/id_rt, id_uses_rs/rt    source registers of the ID instruction
//   id_branch, branch_taken       ID-resolved branch and its outcome
//   ex_memread/ex_regwrite/ex_dst EX instruction info
//   mem_memread/mem_dst           MEM instruction info
//   ext_stall                     global freeze (memory not ready)
//   pc_write, ifid_write, ifid_flush, idex_write, idex_bubble  pipe controls
//   stall_active                  ID is being stalled by a hazard
//   stall_count, flush_count      saturating event counters
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic             branch_taken,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_dst,
    input  logic             mem_memread,
    input  logic [4:0]       mem_dst,
    input  logic             ext_stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {RUN, STALL2} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       match_ex, match_mem;
    logic [1:0] depth;
    logic       stall, flush;

    // Register 0 is hardwired, so it never creates a dependency.
    assign match_ex  = (ex_dst != 5'd0) &&
                       ((id_uses_rs && id_rs == ex_dst) || (id_uses_rt && id_rt == ex_dst));
    assign match_mem = (mem_dst != 5'd0) &&
                       ((id_uses_rs && id_rs == mem_dst) || (id_uses_rt && id_rt == mem_dst));

    // A branch waiting on a load in EX needs the load to reach WB: two bubbles.
    always_comb begin
        depth = 2'd0;
        if (id_branch && ex_memread && match_ex)       depth = 2'd2;
        else if (ex_memread && match_ex)               depth = 2'd1;
        else if (id_branch && ex_regwrite && match_ex) depth = 2'd1;
        else if (id_branch && mem_memread && match_mem) depth = 2'd1;
    end

    // STALL2 stalls without looking at the inputs; a stalled branch flushes
    // only once it finally proceeds.
    assign stall = (state_q == STALL2) || (depth != 2'd0);
    assign flush = !stall && id_branch && branch_taken;

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        ifid_flush   = 1'b0;
        stall_active = rst_n && stall;
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (ext_stall) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_write = 1'b0;
        end else if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            ifid_flush = flush;
        end
    end

    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!ext_stall) begin
            state_d = (state_q == RUN && depth == 2'd2) ? STALL2 : RUN;
            if (stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (flush && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
    logic       id_uses_rs, id_uses_rt, id_branch, branch_taken;
    logic       ex_memread, ex_regwrite, mem_memread, ext_stall;
    logic       pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, stall_active;
    logic [15:0] stall_count, flush_count;
    logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_write, s_idex_bubble, s_stall_active;
    logic [1:0]  s_stall_count, s_flush_count;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_branch(id_branch),
        .branch_taken(branch_taken), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
        .ex_dst(ex_dst), .mem_memread(mem_memread), .mem_dst(mem_dst), .ext_stall(ext_stall),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_write(idex_write), .idex_bubble(idex_bubble), .stall_active(stall_active),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    // Narrow-counter copy to exercise saturation.
    hazard_ctrl #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_branch(id_branch),
        .branch_taken(branch_taken), .ex_memread(ex_memread), .ex_regwrite(ex_regwrite),
        .ex_dst(ex_dst), .mem_memread(mem_memread), .mem_dst(mem_dst), .ext_stall(ext_stall),
        .pc_write(s_pc_write), .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush),
        .idex_write(s_idex_write), .idex_bubble(s_idex_bubble), .stall_active(s_stall_active),
        .stall_count(s_stall_count), .flush_count(s_flush_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_branch = 0; branch_taken = 0; ex_memread = 0; ex_regwrite = 0;
        ex_dst = 0; mem_memread = 0; mem_dst = 0; ext_stall = 0;
    endtask

    // Inputs change 1ns after the edge; outputs are checked 1ns later.
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_branch_load();
        clr(); id_branch = 1; ex_memread = 1; ex_dst = 8; id_rt = 8; id_uses_rt = 1;
    endtask

    initial begin
        clr();
        rst_n = 0;
        #2;
        chk("rst_pc", pc_write, 0);
        chk("rst_ifid", ifid_write, 0);
        chk("rst_idex", idex_write, 0);
        chk("rst_bubble", idex_bubble, 1);
        chk("rst_flush", ifid_flush, 0);
        chk("rst_stall_act", stall_active, 0);
        chk("rst_scnt", stall_count, 0);
        chk("rst_fcnt", flush_count, 0);
        @(negedge clk); rst_n = 1; #1;
        chk("run_pc", pc_write, 1);
        chk("run_bubble", idex_bubble, 0);

        // load-use: single stall
        id_rs = 5; id_uses_rs = 1; ex_memread = 1; ex_dst = 5; #1;
        chk("lu_pc", pc_write, 0);
        chk("lu_ifid", ifid_write, 0);
        chk("lu_idex", idex_write, 1);
        chk("lu_bubble", idex_bubble, 1);
        chk("lu_act", stall_active, 1);
        tick();
        chk("lu_scnt", stall_count, 1);
        chk("lu_scnt_sat", s_stall_count, 1);
        clr(); #1;
        chk("lu_after_pc", pc_write, 1);
        chk("lu_after_act", stall_active, 0);
        tick();
        chk("lu_after_scnt", stall_count, 1);

        // branch after load: two stall cycles, then flush
        set_branch_load(); #1;
        chk("bl_pc0", pc_write, 0);
        tick();
        chk("bl_scnt0", stall_count, 2);
        clr(); id_branch = 1; branch_taken = 1; #1;
        chk("bl_st2_pc", pc_write, 0);
        chk("bl_st2_flush", ifid_flush, 0);
        chk("bl_st2_act", stall_active, 1);
        tick();
        chk("bl_scnt1", stall_count, 3);
        chk("bl_fcnt_hold", flush_count, 0);
        chk("bl_run_flush", ifid_flush, 1);
        chk("bl_run_pc", pc_write, 1);
        tick();
        chk("bl_fcnt", flush_count, 1);

        // branch vs ALU result in EX, then branch vs load in MEM
        clr(); id_branch = 1; ex_regwrite = 1; ex_dst = 8; id_rt = 8; id_uses_rt = 1; #1;
        chk("br_ex_pc", pc_write, 0);
        tick();
        chk("br_ex_scnt", stall_count, 4);
        clr(); id_branch = 1; mem_memread = 1; mem_dst = 8; id_rt = 8; id_uses_rt = 1; #1;
        chk("br_mem_pc", pc_write, 0);
        chk("br_mem_act", stall_active, 1);
        tick();
        chk("br_mem_scnt", stall_count, 5);
        clr(); #1;
        chk("br_mem_next_pc", pc_write, 1);

        // no-hazard corner cases
        ex_memread = 1; ex_dst = 8; id_rt = 8; id_uses_rt = 0; id_rs = 3; id_uses_rs = 1; #1;
        chk("unused_rt_pc", pc_write, 1);
        clr(); ex_memread = 1; ex_dst = 0; id_rs = 0; id_uses_rs = 1; #1;
        chk("r0_pc", pc_write, 1);
        chk("r0_act", stall_active, 0);
        clr(); ex_regwrite = 1; ex_dst = 4; id_rs = 4; id_uses_rs = 1; #1;
        chk("alu_nobr_pc", pc_write, 1);
        tick();
        chk("nohaz_scnt", stall_count, 5);

        // ext_stall freezing STALL2
        set_branch_load(); tick();
        chk("ex_scnt0", stall_count, 6);
        clr(); ext_stall = 1; #1;
        chk("ex_pc", pc_write, 0);
        chk("ex_ifid", ifid_write, 0);
        chk("ex_idex", idex_write, 0);
        chk("ex_bubble", idex_bubble, 0);
        chk("ex_act", stall_active, 1);
        repeat (3) tick();
        chk("ex_scnt_hold", stall_count, 6);
        chk("ex_act_hold", stall_active, 1);
        ext_stall = 0; #1;
        chk("ex_rel_pc", pc_write, 0);
        chk("ex_rel_bubble", idex_bubble, 1);
        tick();
        chk("ex_rel_scnt", stall_count, 7);
        chk("ex_rel_run_pc", pc_write, 1);

        // ext_stall suppresses a taken-branch flush
        id_branch = 1; branch_taken = 1; ext_stall = 1; #1;
        chk("exf_flush", ifid_flush, 0);
        tick();
        chk("exf_fcnt", flush_count, 1);
        ext_stall = 0; #1;
        chk("exf_rel_flush", ifid_flush, 1);
        tick();
        chk("exf_rel_fcnt", flush_count, 2);

        // async reset in the middle of STALL2
        set_branch_load(); tick();
        chk("rs_scnt", stall_count, 8);
        chk("rs_scnt_sat", s_stall_count, 3);
        clr(); rst_n = 0; #1;
        chk("rs_pc", pc_write, 0);
        chk("rs_bubble", idex_bubble, 1);
        chk("rs_act", stall_active, 0);
        chk("rs_scnt0", stall_count, 0);
        chk("rs_fcnt0", flush_count, 0);
        chk("rs_sat0", s_stall_count, 0);
        @(negedge clk); rst_n = 1; #1;
        chk("rs_rel_pc", pc_write, 1);

        // saturation: five consecutive load-use stalls
        id_rs = 5; id_uses_rs = 1; ex_memread = 1; ex_dst = 5;
        repeat (5) tick();
        chk("sat_wide", stall_count, 5);
        chk("sat_narrow", s_stall_count, 3);
        clr(); tick();
        chk("sat_hold", s_stall_count, 3);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
